// File: rtl/matrix_mult_gen.sv
// NxN matrix multiplier with host-loaded A/B/C memories and a single MAC datapath.
// Computes C = A*B or C += A*B, one multiply-accumulate per cycle, row-major storage.
module matrix_mult_gen #(
  parameter int N      = 4,
  parameter int DW     = 8,
  parameter int SIGNED = 0,
  parameter int CW     = 2*DW + $clog2(N),
  localparam int AW    = $clog2(N*N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_mem,
  input  logic          start,
  input  logic          acc_mode,
  input  logic          wenA,
  input  logic          wenB,
  input  logic          wenC,
  input  logic [DW-1:0] wdA,
  input  logic [DW-1:0] wdB,
  input  logic [CW-1:0] wdC,
  input  logic [AW-1:0] addrA,
  input  logic [AW-1:0] addrB,
  input  logic [AW-1:0] addrC,
  output logic [CW-1:0] rdC,
  output logic          busy,
  output logic          done
);

  localparam int NN = N*N;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, MAC, WR, DONE} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
  logic [CW-1:0]   acc_q, acc_d;
  logic            accm_q, accm_d;
  logic [CW-1:0]   rdc_q;
  logic            c_we;

  logic [DW-1:0]   mem_a [NN];
  logic [DW-1:0]   mem_b [NN];
  logic [CW-1:0]   mem_c [NN];

  logic [AW-1:0]   a_idx, b_idx, c_idx;
  logic [CW-1:0]   prod, init;

  function automatic logic [CW-1:0] ext(input logic [DW-1:0] v);
    if (SIGNED != 0) return {{(CW-DW){v[DW-1]}}, v};
    else             return {{(CW-DW){1'b0}}, v};
  endfunction

  function automatic logic in_range(input logic [AW-1:0] a);
    return int'(a) < NN;
  endfunction

  assign a_idx = AW'(int'(i_q) * N + int'(k_q));
  assign b_idx = AW'(int'(k_q) * N + int'(j_q));
  assign c_idx = AW'(int'(i_q) * N + int'(j_q));

  // Modulo-2^CW arithmetic on extended operands gives correct signed or unsigned results.
  assign prod = ext(mem_a[a_idx]) * ext(mem_b[b_idx]);
  assign init = accm_q ? mem_c[c_idx] : '0;

  assign busy = (state_q == MAC) || (state_q == WR);
  assign done = (state_q == DONE);
  assign rdC  = rdc_q;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    accm_d  = accm_q;
    c_we    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (!load_mem && start) begin
          state_d = MAC;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          accm_d  = acc_mode;
        end else if (state_q == DONE && load_mem) begin
          state_d = IDLE;
        end
      end
      MAC: begin
        acc_d = ((k_q == '0) ? init : acc_q) + prod;
        if (k_q == KW'(N-1)) begin
          k_d     = '0;
          state_d = WR;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      WR: begin
        c_we    = 1'b1;
        state_d = MAC;
        if (j_q == KW'(N-1)) begin
          j_d = '0;
          if (i_q == KW'(N-1)) begin
            i_d     = '0;
            state_d = DONE;
          end else begin
            i_d = i_q + KW'(1);
          end
        end else begin
          j_d = j_q + KW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      accm_q  <= 1'b0;
      rdc_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      accm_q  <= accm_d;
      rdc_q   <= in_range(addrC) ? mem_c[addrC] : '0;
    end
  end

  // Memory contents survive reset; an in-flight result write is dropped by reset.
  always_ff @(posedge clk) begin
    if (load_mem && !busy) begin
      if (wenA && in_range(addrA)) mem_a[addrA] <= wdA;
      if (wenB && in_range(addrB)) mem_b[addrB] <= wdB;
      if (wenC && in_range(addrC)) mem_c[addrC] <= wdC;
    end
    if (c_we && !reset) mem_c[c_idx] <= acc_q;
  end

endmodule
